// File: rtl/rvfi_seq_pkg.sv
// rvfi_seq_pkg: shared types and helpers for the RVFI check sequencer.
package rvfi_seq_pkg;
    typedef enum logic [1:0] {RESET_WAIT, COUNT, DONE, ABORT} rvfi_seq_state_t;
    localparam int MAX_NRET = 32;
    localparam int CHAN_W_MAX = $clog2(MAX_NRET);
    function automatic int chan_w(input int nret);
        return nret > 1 ? $clog2(nret) : 1;
    endfunction
    function automatic int unsigned popcount(input logic [MAX_NRET-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_NRET; i++) c += 32'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/rvfi_nth_onehot.sv
// rvfi_nth_onehot: position of the k-th (zero-based) set bit of valid_i, scanning from bit 0.
module rvfi_nth_onehot
    import rvfi_seq_pkg::*;
#(
    parameter int N = 1,
    parameter int KW = 8,
    localparam int PW = chan_w(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [KW-1:0] k_i,
    output logic          found_o,
    output logic [PW-1:0] pos_o
);
    int seen;
    always_comb begin
        found_o = 1'b0;
        pos_o = '0;
        seen = 0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i]) begin
                if (!found_o && seen == int'(k_i)) begin
                    found_o = 1'b1;
                    pos_o = PW'(i);
                end
                seen++;
            end
        end
    end
endmodule

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: counts retirements after reset settle and strobes check on the target one.
module rvfi_check_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET = 1,
    parameter int SKIP = 0,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES = 255,
    parameter int CNTW = 8,
    localparam int CHW = chan_w(NRET)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NRET-1:0] rvfi_valid,
    input  logic [NRET-1:0] rvfi_halt,
    output logic            check,
    output logic [CHW-1:0]  check_channel,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [CNTW-1:0] retire_count
);
    localparam logic [CNTW-1:0] SKIP_C = CNTW'(SKIP);
    localparam logic [CNTW-1:0] RC_LAST = CNTW'(RESET_CYCLES - 1);
    localparam logic [CNTW-1:0] MC_LAST = CNTW'(MAX_CYCLES - 1);
    localparam logic [CNTW-1:0] SAT = '1;
    localparam logic [CNTW-1:0] ONE = CNTW'(1);
    localparam rvfi_seq_state_t ST0 = RESET_CYCLES == 0 ? COUNT : RESET_WAIT;

    rvfi_seq_state_t state_q, state_d;
    logic [CNTW-1:0] cyc_q, cyc_d, cnt_q, cnt_d, k;
    logic            found, hit;
    logic [CHW-1:0]  pos;
    logic [31:0]     sum;

    // Offset of the target within this cycle's retirements; only meaningful when cnt_q <= SKIP.
    assign k = SKIP_C - cnt_q;

    rvfi_nth_onehot #(.N(NRET), .KW(CNTW)) u_nth (
        .valid_i(rvfi_valid),
        .k_i    (k),
        .found_o(found),
        .pos_o  (pos)
    );

    assign sum = 32'(cnt_q) + 32'(popcount(MAX_NRET'(rvfi_valid)));
    assign hit = state_q == COUNT && cnt_q <= SKIP_C && found;
    assign check = hit;
    assign check_channel = hit ? pos : '0;
    assign busy = state_q == RESET_WAIT || state_q == COUNT;
    assign done = state_q == DONE;
    assign aborted = state_q == ABORT;
    assign retire_count = cnt_q;

    always_comb begin
        state_d = state_q;
        cyc_d = busy ? cyc_q + ONE : cyc_q;
        cnt_d = cnt_q;
        if (state_q == RESET_WAIT && cyc_q == RC_LAST) begin
            state_d = COUNT;
            cyc_d = '0;
        end
        if (state_q == COUNT) begin
            cnt_d = sum > 32'(SAT) ? SAT : sum[CNTW-1:0];
            state_d = hit ? DONE : (|(rvfi_valid & rvfi_halt) || cyc_q == MC_LAST) ? ABORT : COUNT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST0;
            cyc_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q <= cyc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
